// File: rtl/dispatch_queue_n.sv
// Dispatch stage between rename and the reservation stations / ROB.
// Renamed packets are buffered in a DEPTH-entry circular queue. The head packet goes to the
// reservation station picked by its FU index, and one ROB entry is allocated in the same
// cycle. Dispatch is in order, at most one packet per cycle.
// Optional feature macro: DISPATCH_BYPASS_EN lets a packet arriving at an empty queue
// dispatch in the same cycle.
module dispatch_queue_n #(
  parameter int unsigned PKT_W  = 128,
  parameter int unsigned FU_W   = 2,
  parameter int unsigned NUM_RS = 3,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PKT_W-1:0]         in_pkt,
  input  logic [FU_W-1:0]          in_fu,
  input  logic [NUM_RS-1:0]        rs_ready_i,
  output logic [NUM_RS-1:0]        rs_valid_o,
  output logic [PKT_W-1:0]         rs_pkt_o,
  input  logic                     rob_ready_i,
  output logic                     rob_alloc_valid_o,
  output logic [PKT_W-1:0]         rob_alloc_pkt_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [1:0]               stall_o,
  output logic                     bad_fu_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  logic [PKT_W-1:0] pkt_mem [DEPTH];
  logic [FU_W-1:0]  fu_mem  [DEPTH];

  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          bad_q, bad_d;

  logic             head_valid, byp, cur_valid, fu_ok, rs_sel;
  logic             fire, drop, pop, enq;
  logic [PKT_W-1:0] cur_pkt;
  logic [FU_W-1:0]  cur_fu;

  assign head_valid = (count_q != '0);
  // Ready depends only on occupancy, never on downstream readiness.
  assign in_ready   = (count_q < DepthC) && !rst;

`ifdef DISPATCH_BYPASS_EN
  // Empty queue: the incoming packet is presented as if it were the head.
  assign byp = !head_valid && in_valid && in_ready && !flush_i;
`else
  assign byp = 1'b0;
`endif

  // Select the presented packet, decode its FU target and derive fire/drop/stall.
  always_comb begin
    cur_valid = head_valid || byp;
    cur_pkt   = '0;
    cur_fu    = '0;
    if (head_valid) begin
      cur_pkt = pkt_mem[head_q];
      cur_fu  = fu_mem[head_q];
    end else if (byp) begin
      cur_pkt = in_pkt;
      cur_fu  = in_fu;
    end

    fu_ok  = 1'b0;
    rs_sel = 1'b0;
    for (int i = 0; i < int'(NUM_RS); i++) begin
      if (cur_fu == FU_W'(i)) begin
        fu_ok  = 1'b1;
        rs_sel = rs_ready_i[i];
      end
    end

    fire = cur_valid && fu_ok && rob_ready_i && rs_sel && !flush_i;
    // Out-of-range FU: consume the packet without any strobe.
    drop = cur_valid && !fu_ok && !flush_i;
    pop  = head_valid && (fire || drop);
    // A bypassed packet that was consumed must not also be written.
    enq  = in_valid && in_ready && !flush_i && !(byp && (fire || drop));

    rs_valid_o = '0;
    for (int i = 0; i < int'(NUM_RS); i++) begin
      rs_valid_o[i] = fire && (cur_fu == FU_W'(i));
    end
    rob_alloc_valid_o = fire;
    rs_pkt_o          = cur_pkt;
    rob_alloc_pkt_o   = cur_pkt;
    stall_o[1]        = cur_valid && fu_ok && !rob_ready_i;
    stall_o[0]        = cur_valid && fu_ok && rob_ready_i && !rs_sel;
  end

  // Next-state for pointers, occupancy and the sticky bad-FU flag.
  always_comb begin
    head_d  = head_q + AW'(pop);
    tail_d  = tail_q + AW'(enq);
    count_d = count_q + CW'(enq) - CW'(pop);
    bad_d   = bad_q || drop;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      bad_d   = 1'b0;
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      bad_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      bad_q   <= bad_d;
    end
  end

  // Queue storage; contents are only meaningful below count_q, so no reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      pkt_mem[tail_q] <= in_pkt;
      fu_mem[tail_q]  <= in_fu;
    end
  end

  assign count_o  = count_q;
  assign bad_fu_o = bad_q;

endmodule
